// File: rtl/mem_freeze_ctrl.sv
// mem_freeze_ctrl
//   Multi-channel pipeline freeze controller. Each of NCH memory channels runs
//   a MOVE/FREEZE/ERR state machine; the CPU is held while any enabled channel
//   is in FREEZE. A channel stuck in FREEZE for TIMEOUT cycles drops to ERR,
//   raises a sticky timeout flag and stops requesting freeze.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   ch_state      per-channel status, channel i at [3i+2:3i]
//                 (000 FREE, 111 STALL, other HOLD)
//   ch_en         per-channel enable; disabled channel is forced to MOVE
//   err_clr       pulse, clears timeout_err (a simultaneous timeout wins)
//   cnt_clr       pulse, clears freeze_cycles (wins over increment)
//   freeze        OR of freeze_ch
//   freeze_ch     per-channel freeze request (registered state decode)
//   timeout_err   sticky per-channel timeout flags
//   freeze_cycles saturating count of cycles with freeze high
module mem_freeze_ctrl #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3*NCH-1:0]   ch_state,
  input  logic [NCH-1:0]     ch_en,
  input  logic               err_clr,
  input  logic               cnt_clr,
  output logic               freeze,
  output logic [NCH-1:0]     freeze_ch,
  output logic [NCH-1:0]     timeout_err,
  output logic [CNT_W-1:0]   freeze_cycles
);

  typedef enum logic [1:0] {
    MOVE   = 2'b00,
    FREEZE = 2'b01,
    ERR    = 2'b10
  } state_t;

  localparam logic [2:0]  CODE_FREE  = 3'b000;
  localparam logic [2:0]  CODE_STALL = 3'b111;
  localparam logic [15:0] TCNT_LAST  = 16'(TIMEOUT - 1);

  state_t         state_q [NCH];
  state_t         state_d [NCH];
  logic [15:0]    tcnt_q  [NCH];
  logic [15:0]    tcnt_d  [NCH];
  logic [NCH-1:0] err_q;
  logic [NCH-1:0] err_d;
  logic [2:0]     code;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= MOVE;
        tcnt_q[i]  <= '0;
      end
      err_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        tcnt_q[i]  <= tcnt_d[i];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    code  = '0;
    // Clear is applied first so a timeout on the same edge re-sets the flag.
    err_d = err_clr ? '0 : err_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      code       = ch_state[3*i +: 3];
      state_d[i] = state_q[i];
      tcnt_d[i]  = tcnt_q[i];
      if (!ch_en[i]) begin
        state_d[i] = MOVE;
        tcnt_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          MOVE: begin
            if (code == CODE_STALL) begin
              state_d[i] = FREEZE;
              tcnt_d[i]  = '0;
            end
          end
          FREEZE: begin
            if (code == CODE_FREE) begin
              state_d[i] = MOVE;
            end else if (tcnt_q[i] == TCNT_LAST) begin
              state_d[i] = ERR;
              err_d[i]   = 1'b1;
            end else begin
              tcnt_d[i] = tcnt_q[i] + 16'd1;
            end
          end
          ERR: begin
            if (code == CODE_FREE) begin
              state_d[i] = MOVE;
            end
          end
          default: begin
            state_d[i] = MOVE;
            tcnt_d[i]  = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    freeze_ch = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      freeze_ch[i] = (state_q[i] == FREEZE);
    end
  end

  assign freeze      = |freeze_ch;
  assign timeout_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freeze_cycles <= '0;
    end else if (cnt_clr) begin
      freeze_cycles <= '0;
    end else if (freeze && (freeze_cycles != '1)) begin
      freeze_cycles <= freeze_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_freeze_ctrl.sv
// Self-checking bench for mem_freeze_ctrl (NCH=2, TIMEOUT=8, CNT_W=4).
// A behavioural model tracks each channel as "moving", "frozen for N cycles"
// or "dead", and the bench compares every output after each clock edge.
module tb_mem_freeze_ctrl;
  localparam int NCH = 2;
  localparam int TO  = 8;
  localparam int CW  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3*NCH-1:0] ch_state = '0;
  logic [NCH-1:0]   ch_en = '1;
  logic             err_clr = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             freeze;
  logic [NCH-1:0]   freeze_ch;
  logic [NCH-1:0]   timeout_err;
  logic [CW-1:0]    freeze_cycles;

  mem_freeze_ctrl #(.NCH(NCH), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ch_state(ch_state), .ch_en(ch_en),
    .err_clr(err_clr), .cnt_clr(cnt_clr), .freeze(freeze),
    .freeze_ch(freeze_ch), .timeout_err(timeout_err),
    .freeze_cycles(freeze_cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: mode 0 = moving, 1 = frozen, 2 = dead; age = edges spent frozen
  int m_mode [NCH];
  int m_age  [NCH];
  bit m_err  [NCH];
  int m_cnt;

  logic [8:0] exp_v, act_v;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = 0; m_age[i] = 0; m_err[i] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_edge();
    bit cur_f;
    int code;
    cur_f = 0;
    for (int i = 0; i < NCH; i++) if (m_mode[i] == 1) cur_f = 1;
    if (cnt_clr) m_cnt = 0;
    else if (cur_f && m_cnt < (2**CW) - 1) m_cnt = m_cnt + 1;
    for (int i = 0; i < NCH; i++) begin
      code = int'(ch_state[3*i +: 3]);
      if (err_clr) m_err[i] = 0;
      if (!ch_en[i]) begin
        m_mode[i] = 0; m_age[i] = 0;
      end else if (m_mode[i] == 0) begin
        if (code == 7) begin m_mode[i] = 1; m_age[i] = 0; end
      end else if (m_mode[i] == 1) begin
        if (code == 0) m_mode[i] = 0;
        else begin
          m_age[i] = m_age[i] + 1;
          if (m_age[i] == TO) begin m_mode[i] = 2; m_err[i] = 1; end
        end
      end else if (code == 0) begin
        m_mode[i] = 0;
      end
    end
  endtask

  task automatic make_exp();
    logic [NCH-1:0] fc, er;
    for (int i = 0; i < NCH; i++) begin
      fc[i] = (m_mode[i] == 1);
      er[i] = m_err[i];
    end
    exp_v = {|fc, fc, er, 4'(m_cnt)};
    act_v = {freeze, freeze_ch, timeout_err, freeze_cycles};
  endtask

  // advance one rising edge, update the model, sample 1 time unit later
  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    make_exp();
  endtask

  task automatic test_reset();
    model_reset();
    ch_state = {3'b111, 3'b000};
    ch_en = 2'b11;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({freeze, freeze_ch, timeout_err, freeze_cycles} !== 9'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b required 0", {freeze, freeze_ch, timeout_err, freeze_cycles});
      end
    end
    @(negedge clk) rst = 1'b1;
    step();
    n_tests++;
    if (freeze_ch !== 2'b10 || freeze !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_stall: freeze_ch=%b freeze=%b required 10/1", freeze_ch, freeze);
    end
    ch_state = '0;
    step();
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_release_model: got %b expected %b", act_v, exp_v);
    end
  endtask

  task automatic test_hold_free();
    logic [2:0] seq [6] = '{3'b111, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
    int hf = 0;
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ch_state = {3'b000, seq[k]};
      step();
      if (freeze) hf++;
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL hold_free[%0d]: got %b expected %b", k, act_v, exp_v);
      end
    end
    // high after the STALL edge and the four HOLD edges, dropped after FREE
    n_tests++;
    if (hf != 5 || freeze_cycles !== 4'd5 || timeout_err !== 2'b00) begin
      n_fail++;
      $display("FAIL hold_free_len: high=%0d cnt=%0d err=%b required 5/5/00", hf, freeze_cycles, timeout_err);
    end
  endtask

  task automatic test_timeout();
    int hf = 0;
    ch_state = '0; step();
    ch_state = {3'b000, 3'b111};
    for (int k = 0; k < TO + 4; k++) begin
      step();
      if (freeze) hf++;
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL timeout_seq[%0d]: got %b expected %b", k, act_v, exp_v);
      end
    end
    n_tests++;
    if (hf != TO || timeout_err !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_len: high=%0d err=%b required %0d/01", hf, timeout_err, TO);
    end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_tests++;
    if (timeout_err !== 2'b00 || freeze !== 1'b0 || act_v !== exp_v) begin
      n_fail++;
      $display("FAIL timeout_errclr: got %b expected %b", act_v, exp_v);
    end
    ch_state = '0; step();
    ch_state = {3'b000, 3'b111}; step();
    n_tests++;
    if (freeze !== 1'b1 || act_v !== exp_v) begin
      n_fail++;
      $display("FAIL timeout_recover: got %b expected %b", act_v, exp_v);
    end
    // v=0: FREE on the timeout edge; v=1: err_clr on the timeout edge
    for (int v = 0; v < 2; v++) begin
      ch_state = '0; err_clr = 1'b1; step(); err_clr = 1'b0;
      ch_state = {3'b000, 3'b111}; step();
      for (int k = 1; k < TO; k++) step();
      if (v == 0) ch_state = '0; else err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      n_tests++;
      if (timeout_err !== (v == 0 ? 2'b00 : 2'b01) || freeze !== 1'b0 || act_v !== exp_v) begin
        n_fail++;
        $display("FAIL timeout_edge_v%0d: got %b expected %b", v, act_v, exp_v);
      end
    end
    ch_state = '0; err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  task automatic test_two_channels();
    int hf = 0;
    logic [2:0] c0, c1;
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    for (int e = 0; e < 8; e++) begin
      c0 = (e == 0) ? 3'b111 : (e >= 3 ? 3'b000 : 3'b011);
      c1 = (e == 0) ? 3'b111 : (e >= 6 ? 3'b000 : 3'b101);
      ch_state = {c1, c0};
      step();
      if (freeze) hf++;
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL two_ch[%0d]: got %b expected %b", e, act_v, exp_v);
      end
    end
    n_tests++;
    if (hf != 6 || freeze_cycles !== 4'd6) begin
      n_fail++;
      $display("FAIL two_ch_len: high=%0d cnt=%0d required 6/6", hf, freeze_cycles);
    end
  endtask

  task automatic test_enable();
    ch_state = {3'b111, 3'b000}; step();
    ch_state = {3'b010, 3'b000}; ch_en = 2'b01; step();
    n_tests++;
    if (freeze_ch !== 2'b00 || act_v !== exp_v) begin
      n_fail++;
      $display("FAIL enable_drop: got %b expected %b", act_v, exp_v);
    end
    ch_en = 2'b11; step();
    n_tests++;
    if (freeze_ch !== 2'b00 || act_v !== exp_v) begin
      n_fail++;
      $display("FAIL enable_hold_move: got %b expected %b", act_v, exp_v);
    end
    ch_state = {3'b111, 3'b000}; ch_en = 2'b01; step();
    n_tests++;
    if (freeze_ch !== 2'b00 || act_v !== exp_v) begin
      n_fail++;
      $display("FAIL enable_with_stall: got %b expected %b", act_v, exp_v);
    end
    ch_en = 2'b11; ch_state = '0; step();
  endtask

  task automatic test_saturate();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    for (int t = 0; t < 40; t++) begin
      ch_state = {3'b000, (t % 6 == 5) ? 3'b000 : 3'b111};
      step();
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got %b expected %b", t, act_v, exp_v);
      end
    end
    n_tests++;
    if (freeze_cycles !== 4'd15) begin
      n_fail++;
      $display("FAIL saturate_max: got %0d required 15", freeze_cycles);
    end
    ch_state = '0; step();
    ch_state = {3'b000, 3'b111}; step();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    n_tests++;
    if (freeze_cycles !== 4'd0 || freeze !== 1'b1) begin
      n_fail++;
      $display("FAIL cnt_clr_wins: cnt=%0d freeze=%b required 0/1", freeze_cycles, freeze);
    end
    for (int k = 1; k <= 2; k++) begin
      step();
      n_tests++;
      if (freeze_cycles !== 4'(k)) begin
        n_fail++;
        $display("FAIL cnt_resume[%0d]: got %0d required %0d", k, freeze_cycles, k);
      end
    end
    ch_state = '0; step();
  endtask

  task automatic test_reset_midfreeze();
    ch_state = {3'b000, 3'b111}; step();
    @(negedge clk); #2 rst = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({freeze, freeze_ch, timeout_err, freeze_cycles} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %b required 0", {freeze, freeze_ch, timeout_err, freeze_cycles});
    end
    @(negedge clk) rst = 1'b1;
    #1;
    n_tests++;
    if (freeze !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_noedge: freeze=%b required 0", freeze);
    end
    step();
    n_tests++;
    if (freeze !== 1'b1 || act_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_restall: got %b expected %b", act_v, exp_v);
    end
    ch_state = '0; step();
  endtask

  task automatic test_random();
    int r;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NCH; i++) begin
        r = $urandom_range(0, 9);
        if (r < 2)      ch_state[3*i +: 3] = 3'b000;
        else if (r < 5) ch_state[3*i +: 3] = 3'b111;
        else            ch_state[3*i +: 3] = 3'($urandom_range(1, 6));
        ch_en[i] = ($urandom_range(0, 19) != 0);
      end
      err_clr = ($urandom_range(0, 15) == 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      step();
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b expected %b", t, act_v, exp_v);
      end
    end
    err_clr = 1'b0; cnt_clr = 1'b0; ch_en = '1; ch_state = '0;
  endtask

  initial begin
    test_reset();
    test_hold_free();
    test_timeout();
    test_two_channels();
    test_enable();
    test_saturate();
    test_reset_midfreeze();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
